// File: rtl/rv_seq_ctrl_pkg.sv
// Shared definitions for the RV multi-cycle sequencer: state codes and legal opcodes.
package rv_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  function automatic logic op_legal(input logic [6:0] op);
    return op inside {OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH};
  endfunction

endpackage

// File: rtl/rv_seq_ctrl_if.sv
// Instruction/data memory handshake bundle between the sequencer and the memories.
interface rv_seq_ctrl_if;
  logic imem_req_o;
  logic imem_ready_i;
  logic ir_load_o;
  logic dmem_rd_o;
  logic dmem_wr_o;
  logic dmem_ready_i;

  modport master (
    output imem_req_o, ir_load_o, dmem_rd_o, dmem_wr_o,
    input  imem_ready_i, dmem_ready_i
  );

  modport slave (
    input  imem_req_o, ir_load_o, dmem_rd_o, dmem_wr_o,
    output imem_ready_i, dmem_ready_i
  );
endinterface

// File: rtl/rv_seq_ctrl_wait_timer.sv
// Clear/enable wait counter; tc flags the last permitted wait cycle and the count holds there.
module rv_seq_ctrl_wait_timer #(
  parameter int LIMIT = 16,
  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/rv_seq_ctrl.sv
// Multi-cycle instruction sequencer: steps FETCH/DECODE/EXEC/MEM/WB, gates datapath
// strobes from the current state, and traps illegal opcodes and data-memory timeouts.
module rv_seq_ctrl
  import rv_seq_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             run_i,
  input  logic             halt_req_i,
  input  logic             resume_i,
  rv_seq_ctrl_if.master    bus,
  input  logic [6:0]       opcode_i,
  input  logic             reg_write_i,
  input  logic             mem_read_i,
  input  logic             mem_write_i,
  output logic             rf_wr_en_o,
  output logic             pc_load_o,
  output logic [2:0]       state_o,
  output logic             illegal_o,
  output logic             bus_err_o,
  output logic [CNT_W-1:0] retired_o
);

  state_t state;
  logic   tmr_tc;

  // Timer restarts from zero on every entry into MEM because it is held clear elsewhere.
  rv_seq_ctrl_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
    .clk  (clk),
    .rstn (rstn),
    .clr  (state != S_MEM),
    .en   (state == S_MEM),
    .tc   (tmr_tc)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      illegal_o <= 1'b0;
      bus_err_o <= 1'b0;
      retired_o <= '0;
    end else begin
      case (state)
        S_IDLE:   if (run_i) state <= S_FETCH;
        S_FETCH:  if (bus.imem_ready_i) state <= S_DECODE;
        S_DECODE: begin
          if (op_legal(opcode_i)) begin
            state <= S_EXEC;
          end else begin
            illegal_o <= 1'b1;
            state     <= S_HALT;
          end
        end
        S_EXEC:   state <= (mem_read_i || mem_write_i) ? S_MEM : S_WB;
        S_MEM: begin
          // A ready arriving on the terminal cycle still completes the access.
          if (bus.dmem_ready_i) begin
            state <= S_WB;
          end else if (tmr_tc) begin
            bus_err_o <= 1'b1;
            state     <= S_HALT;
          end
        end
        S_WB: begin
          retired_o <= retired_o + 1'b1;
          if (halt_req_i)  state <= S_HALT;
          else if (!run_i) state <= S_IDLE;
          else             state <= S_FETCH;
        end
        S_HALT: begin
          if (resume_i && !illegal_o && !bus_err_o && !halt_req_i) state <= S_FETCH;
        end
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Strobes respond combinationally in the same cycle; read wins if rv_ctrl ever raises both.
  assign bus.imem_req_o = (state == S_FETCH);
  assign bus.ir_load_o  = (state == S_FETCH) && bus.imem_ready_i;
  assign bus.dmem_rd_o  = (state == S_MEM) && mem_read_i;
  assign bus.dmem_wr_o  = (state == S_MEM) && mem_write_i && !mem_read_i;
  assign rf_wr_en_o     = (state == S_WB) && reg_write_i;
  assign pc_load_o      = (state == S_WB);
  assign state_o        = state;

endmodule
